// File: rtl/useq_controller.sv
// Microsequencer: picks the next uPC each cycle from the microword sequencing field (inc/jump/branch/dispatch/call/ret/fetch/wait).
// Latency: upc, sp, instr_done and fault_code are registered, so the effect of an op is visible one cycle later.
// Backpressure: stall=1 freezes upc, sp and the stack, and the op is not evaluated; a stack fault halts until reset.
//
// Ports:
//   clk, rst        clock; synchronous active-low reset
//   useq_op/cond    sequencing op and branch/wait condition select of the current microword
//   useq_addr       target for JUMP/BRANCH/CALL
//   flags           {V,C,N,Z} from the ALU; irq_pend is condition 7
//   ir_opcode/valid opcode for DISPATCH; dispatch waits while ir_valid=0
//   stall           freeze request from datapath/memory
//   upc             current micro-PC (control store address)
//   instr_done      one-cycle pulse after a FETCH op
//   sp              microstack occupancy
//   fault           high while halted on stack overflow/underflow
//   fault_code      01 overflow, 10 underflow, 00 none
module useq_controller #(
  parameter int UPC_W = 12,
  parameter logic [UPC_W-1:0] FETCH_ADDR = '0,
  parameter logic [UPC_W-1:0] DISP_BASE = UPC_W'(256),
  parameter int DISP_SHIFT = 2,
  parameter int STACK_DEPTH = 4,
  localparam int SP_W = $clog2(STACK_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       useq_op,
  input  logic [2:0]       useq_cond,
  input  logic [UPC_W-1:0] useq_addr,
  input  logic [3:0]       flags,
  input  logic             irq_pend,
  input  logic [7:0]       ir_opcode,
  input  logic             ir_valid,
  input  logic             stall,
  output logic [UPC_W-1:0] upc,
  output logic             instr_done,
  output logic [SP_W-1:0]  sp,
  output logic             fault,
  output logic [1:0]       fault_code
);

  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  localparam logic [2:0] OP_NEXT   = 3'd0;
  localparam logic [2:0] OP_JUMP   = 3'd1;
  localparam logic [2:0] OP_BRANCH = 3'd2;
  localparam logic [2:0] OP_DISP   = 3'd3;
  localparam logic [2:0] OP_CALL   = 3'd4;
  localparam logic [2:0] OP_RET    = 3'd5;
  localparam logic [2:0] OP_FETCH  = 3'd6;
  localparam logic [2:0] OP_WAIT   = 3'd7;

  typedef enum logic {RUN, HALT} state_t;

  state_t           state_q, state_d;
  logic [UPC_W-1:0] upc_d;
  logic [SP_W-1:0]  sp_d;
  logic             done_d;
  logic [1:0]       code_d;
  logic             push;
  logic             cond_true;
  logic             stack_full, stack_empty;
  logic [UPC_W-1:0] inc, disp_tgt, stack_top;
  logic [IDX_W-1:0] push_idx, pop_idx;
  logic [UPC_W-1:0] stack_q [STACK_DEPTH];

  // Wraps naturally at 2**UPC_W; the pushed return address uses the same value.
  assign inc = upc + UPC_W'(1);

  // Shift in a widened word, then truncate: dispatch wraps silently.
  assign disp_tgt = DISP_BASE + UPC_W'({{UPC_W{1'b0}}, ir_opcode} << DISP_SHIFT);

  assign stack_full  = (sp == SP_W'(STACK_DEPTH));
  assign stack_empty = (sp == '0);
  assign push_idx    = IDX_W'(sp);
  assign pop_idx     = IDX_W'(sp - SP_W'(1));
  assign stack_top   = stack_q[pop_idx];

  assign fault = (state_q == HALT);

  always_comb begin
    cond_true = 1'b0;
    case (useq_cond)
      3'd0:    cond_true = 1'b1;
      3'd1:    cond_true = flags[0];
      3'd2:    cond_true = ~flags[0];
      3'd3:    cond_true = flags[1];
      3'd4:    cond_true = flags[2];
      3'd5:    cond_true = ~flags[2];
      3'd6:    cond_true = flags[3];
      3'd7:    cond_true = irq_pend;
      default: cond_true = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    upc_d   = upc;
    sp_d    = sp;
    done_d  = 1'b0;
    code_d  = fault_code;
    push    = 1'b0;
    if (state_q == RUN && !stall) begin
      case (useq_op)
        OP_NEXT:   upc_d = inc;
        OP_JUMP:   upc_d = useq_addr;
        OP_BRANCH: upc_d = cond_true ? useq_addr : inc;
        OP_DISP:   if (ir_valid) upc_d = disp_tgt;
        OP_CALL: begin
          if (stack_full) begin
            state_d = HALT;
            code_d  = 2'b01;
          end else begin
            push  = 1'b1;
            sp_d  = sp + SP_W'(1);
            upc_d = useq_addr;
          end
        end
        OP_RET: begin
          if (stack_empty) begin
            state_d = HALT;
            code_d  = 2'b10;
          end else begin
            upc_d = stack_top;
            sp_d  = sp - SP_W'(1);
          end
        end
        OP_FETCH: begin
          upc_d  = FETCH_ADDR;
          done_d = 1'b1;
        end
        OP_WAIT:   if (cond_true) upc_d = inc;
        default:   ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= RUN;
      upc        <= FETCH_ADDR;
      sp         <= '0;
      instr_done <= 1'b0;
      fault_code <= 2'b00;
    end else begin
      state_q    <= state_d;
      upc        <= upc_d;
      sp         <= sp_d;
      instr_done <= done_d;
      fault_code <= code_d;
    end
  end

  // Stack contents need no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) stack_q[push_idx] <= inc;
  end

endmodule

// File: tb/tb_useq_controller.sv
module tb_useq_controller;

  localparam logic [2:0] NXT = 3'd0, JMP = 3'd1, BR = 3'd2, DSP = 3'd3,
                         CAL = 3'd4, RET = 3'd5, FET = 3'd6, WT = 3'd7;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  useq_op, useq_cond;
  logic [11:0] useq_addr;
  logic [3:0]  flags;
  logic        irq_pend;
  logic [7:0]  ir_opcode;
  logic        ir_valid;
  logic        stall;
  logic [11:0] upc;
  logic        instr_done;
  logic [2:0]  sp;
  logic        fault;
  logic [1:0]  fault_code;

  int n_total = 0;
  int n_pass  = 0;

  useq_controller dut (
    .clk(clk), .rst(rst), .useq_op(useq_op), .useq_cond(useq_cond),
    .useq_addr(useq_addr), .flags(flags), .irq_pend(irq_pend),
    .ir_opcode(ir_opcode), .ir_valid(ir_valid), .stall(stall),
    .upc(upc), .instr_done(instr_done), .sp(sp), .fault(fault),
    .fault_code(fault_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [2:0]  op;
    logic [2:0]  cond;
    logic [11:0] addr;
    logic [3:0]  flags;
    logic        irq;
    logic [7:0]  opc;
    logic        irv;
    logic        stall;
    logic [11:0] e_upc;
    logic [2:0]  e_sp;
    logic        e_done;
    logic        e_fault;
    logic [1:0]  e_code;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [2:0] op, input logic [2:0] cond,
                     input logic [11:0] addr, input logic [3:0] fl, input logic irq,
                     input logic [7:0] opc, input logic irv, input logic st,
                     input logic [11:0] eu, input logic [2:0] es, input logic ed,
                     input logic ef, input logic [1:0] ec);
    vec_t v;
    v.rst = r; v.op = op; v.cond = cond; v.addr = addr; v.flags = fl; v.irq = irq;
    v.opc = opc; v.irv = irv; v.stall = st;
    v.e_upc = eu; v.e_sp = es; v.e_done = ed; v.e_fault = ef; v.e_code = ec;
    vecs.push_back(v);
  endtask

  // Shorthand for the common case: no reset, no flags/irq/opcode, no stall.
  task automatic add_op(input logic [2:0] op, input logic [11:0] addr,
                        input logic [11:0] eu, input logic [2:0] es, input logic ed,
                        input logic ef, input logic [1:0] ec);
    add(1'b1, op, 3'd0, addr, 4'h0, 1'b0, 8'h00, 1'b0, 1'b0, eu, es, ed, ef, ec);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic drive(input logic r, input logic [2:0] op, input logic [2:0] cond,
                       input logic [11:0] addr, input logic [3:0] fl, input logic irq,
                       input logic [7:0] opc, input logic irv, input logic st);
    rst = r; useq_op = op; useq_cond = cond; useq_addr = addr; flags = fl;
    irq_pend = irq; ir_opcode = opc; ir_valid = irv; stall = st;
  endtask

  initial begin
    int pulses;
    bit seen;
    drive(1'b0, JMP, 3'd0, 12'h123, 4'h0, 1'b0, 8'h00, 1'b0, 1'b0);

    // Reset with JUMP on the inputs, then NEXT x3
    add(1'b0, JMP, 3'd0, 12'h123, 4'h0, 1'b0, 8'h00, 1'b0, 1'b0, 12'h000, 3'd0, 1'b0, 1'b0, 2'b00);
    add(1'b0, JMP, 3'd0, 12'h123, 4'h0, 1'b0, 8'h00, 1'b0, 1'b0, 12'h000, 3'd0, 1'b0, 1'b0, 2'b00);
    add_op(NXT, 12'h000, 12'h001, 3'd0, 1'b0, 1'b0, 2'b00);
    add_op(NXT, 12'h000, 12'h002, 3'd0, 1'b0, 1'b0, 2'b00);
    add_op(NXT, 12'h000, 12'h003, 3'd0, 1'b0, 1'b0, 2'b00);
    add(1'b0, NXT, 3'd0, 12'h000, 4'h0, 1'b0, 8'h00, 1'b0, 1'b0, 12'h000, 3'd0, 1'b0, 1'b0, 2'b00);
    // NOP trace: 000 -> 001 -> 100 -> 000 with instr_done pulse
    add_op(NXT, 12'h000, 12'h001, 3'd0, 1'b0, 1'b0, 2'b00);
    add(1'b1, DSP, 3'd0, 12'h000, 4'h0, 1'b0, 8'h00, 1'b1, 1'b0, 12'h100, 3'd0, 1'b0, 1'b0, 2'b00);
    add_op(FET, 12'h000, 12'h000, 3'd0, 1'b1, 1'b0, 2'b00);
    add_op(NXT, 12'h000, 12'h001, 3'd0, 1'b0, 1'b0, 2'b00);
    // Dispatch waits for ir_valid, then 0x3F -> 0x1FC, 0xFF -> 0x4FC
    for (int i = 0; i < 3; i++)
      add(1'b1, DSP, 3'd0, 12'h000, 4'h0, 1'b0, 8'h3F, 1'b0, 1'b0, 12'h001, 3'd0, 1'b0, 1'b0, 2'b00);
    add(1'b1, DSP, 3'd0, 12'h000, 4'h0, 1'b0, 8'h3F, 1'b1, 1'b0, 12'h1FC, 3'd0, 1'b0, 1'b0, 2'b00);
    add(1'b1, DSP, 3'd0, 12'h000, 4'h0, 1'b0, 8'hFF, 1'b1, 1'b0, 12'h4FC, 3'd0, 1'b0, 1'b0, 2'b00);
    // Branch conditions ({V,C,N,Z})
    add(1'b1, BR, 3'd1, 12'h050, 4'h0, 1'b0, 8'h00, 1'b0, 1'b0, 12'h4FD, 3'd0, 1'b0, 1'b0, 2'b00);
    add(1'b1, BR, 3'd1, 12'h050, 4'h1, 1'b0, 8'h00, 1'b0, 1'b0, 12'h050, 3'd0, 1'b0, 1'b0, 2'b00);
    add(1'b1, BR, 3'd2, 12'h070, 4'h1, 1'b0, 8'h00, 1'b0, 1'b0, 12'h051, 3'd0, 1'b0, 1'b0, 2'b00);
    add(1'b1, BR, 3'd4, 12'h200, 4'h4, 1'b0, 8'h00, 1'b0, 1'b0, 12'h200, 3'd0, 1'b0, 1'b0, 2'b00);
    add(1'b1, BR, 3'd6, 12'h300, 4'h8, 1'b0, 8'h00, 1'b0, 1'b0, 12'h300, 3'd0, 1'b0, 1'b0, 2'b00);
    add(1'b1, BR, 3'd3, 12'h010, 4'hD, 1'b0, 8'h00, 1'b0, 1'b0, 12'h301, 3'd0, 1'b0, 1'b0, 2'b00);
    add(1'b1, BR, 3'd3, 12'h010, 4'h2, 1'b0, 8'h00, 1'b0, 1'b0, 12'h010, 3'd0, 1'b0, 1'b0, 2'b00);
    add(1'b1, BR, 3'd5, 12'h020, 4'h0, 1'b0, 8'h00, 1'b0, 1'b0, 12'h020, 3'd0, 1'b0, 1'b0, 2'b00);
    add(1'b1, BR, 3'd0, 12'h030, 4'h0, 1'b0, 8'h00, 1'b0, 1'b0, 12'h030, 3'd0, 1'b0, 1'b0, 2'b00);
    // WAIT on irq_pend
    add(1'b1, WT, 3'd7, 12'h000, 4'hF, 1'b0, 8'h00, 1'b0, 1'b0, 12'h030, 3'd0, 1'b0, 1'b0, 2'b00);
    add(1'b1, WT, 3'd7, 12'h000, 4'hF, 1'b0, 8'h00, 1'b0, 1'b0, 12'h030, 3'd0, 1'b0, 1'b0, 2'b00);
    add(1'b1, WT, 3'd7, 12'h000, 4'h0, 1'b1, 8'h00, 1'b0, 1'b0, 12'h031, 3'd0, 1'b0, 1'b0, 2'b00);
    // Nested calls from 010/020/030/040, returns, then underflow
    add_op(JMP, 12'h010, 12'h010, 3'd0, 1'b0, 1'b0, 2'b00);
    add_op(CAL, 12'h020, 12'h020, 3'd1, 1'b0, 1'b0, 2'b00);
    add_op(CAL, 12'h030, 12'h030, 3'd2, 1'b0, 1'b0, 2'b00);
    add_op(CAL, 12'h040, 12'h040, 3'd3, 1'b0, 1'b0, 2'b00);
    add_op(CAL, 12'h050, 12'h050, 3'd4, 1'b0, 1'b0, 2'b00);
    add_op(RET, 12'h000, 12'h041, 3'd3, 1'b0, 1'b0, 2'b00);
    add_op(RET, 12'h000, 12'h031, 3'd2, 1'b0, 1'b0, 2'b00);
    add_op(RET, 12'h000, 12'h021, 3'd1, 1'b0, 1'b0, 2'b00);
    add_op(RET, 12'h000, 12'h011, 3'd0, 1'b0, 1'b0, 2'b00);
    add_op(RET, 12'h000, 12'h011, 3'd0, 1'b0, 1'b1, 2'b10);
    add_op(NXT, 12'h000, 12'h011, 3'd0, 1'b0, 1'b1, 2'b10);
    add_op(FET, 12'h000, 12'h011, 3'd0, 1'b0, 1'b1, 2'b10);
    add(1'b0, NXT, 3'd0, 12'h000, 4'h0, 1'b0, 8'h00, 1'b0, 1'b0, 12'h000, 3'd0, 1'b0, 1'b0, 2'b00);
    // Overflow on the 5th CALL
    add_op(CAL, 12'h100, 12'h100, 3'd1, 1'b0, 1'b0, 2'b00);
    add_op(CAL, 12'h200, 12'h200, 3'd2, 1'b0, 1'b0, 2'b00);
    add_op(CAL, 12'h300, 12'h300, 3'd3, 1'b0, 1'b0, 2'b00);
    add_op(CAL, 12'h400, 12'h400, 3'd4, 1'b0, 1'b0, 2'b00);
    add_op(CAL, 12'h500, 12'h400, 3'd4, 1'b0, 1'b1, 2'b01);
    add_op(JMP, 12'h123, 12'h400, 3'd4, 1'b0, 1'b1, 2'b01);
    add(1'b0, NXT, 3'd0, 12'h000, 4'h0, 1'b0, 8'h00, 1'b0, 1'b0, 12'h000, 3'd0, 1'b0, 1'b0, 2'b00);
    // Stall freezes everything
    add(1'b1, CAL, 3'd0, 12'h080, 4'h0, 1'b0, 8'h00, 1'b0, 1'b1, 12'h000, 3'd0, 1'b0, 1'b0, 2'b00);
    add(1'b1, RET, 3'd0, 12'h000, 4'h0, 1'b0, 8'h00, 1'b0, 1'b1, 12'h000, 3'd0, 1'b0, 1'b0, 2'b00);
    add(1'b1, FET, 3'd0, 12'h000, 4'h0, 1'b0, 8'h00, 1'b0, 1'b1, 12'h000, 3'd0, 1'b0, 1'b0, 2'b00);
    add_op(CAL, 12'h080, 12'h080, 3'd1, 1'b0, 1'b0, 2'b00);
    // Wrap: NEXT at FFF, CALL at FFF pushes 000
    add_op(JMP, 12'hFFF, 12'hFFF, 3'd1, 1'b0, 1'b0, 2'b00);
    add_op(NXT, 12'h000, 12'h000, 3'd1, 1'b0, 1'b0, 2'b00);
    add_op(JMP, 12'hFFF, 12'hFFF, 3'd1, 1'b0, 1'b0, 2'b00);
    add_op(CAL, 12'h200, 12'h200, 3'd2, 1'b0, 1'b0, 2'b00);
    add_op(RET, 12'h000, 12'h000, 3'd1, 1'b0, 1'b0, 2'b00);
    add_op(CAL, 12'h300, 12'h300, 3'd2, 1'b0, 1'b0, 2'b00);
    // Mid-call reset discards the stack
    add(1'b0, NXT, 3'd0, 12'h000, 4'h0, 1'b0, 8'h00, 1'b0, 1'b0, 12'h000, 3'd0, 1'b0, 1'b0, 2'b00);
    add_op(RET, 12'h000, 12'h000, 3'd0, 1'b0, 1'b1, 2'b10);
    add(1'b0, NXT, 3'd0, 12'h000, 4'h0, 1'b0, 8'h00, 1'b0, 1'b0, 12'h000, 3'd0, 1'b0, 1'b0, 2'b00);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].op, vecs[i].cond, vecs[i].addr, vecs[i].flags,
            vecs[i].irq, vecs[i].opc, vecs[i].irv, vecs[i].stall);
      @(posedge clk);
      #1;
      check($sformatf("v%0d upc", i),        32'(upc),        32'(vecs[i].e_upc));
      check($sformatf("v%0d sp", i),         32'(sp),         32'(vecs[i].e_sp));
      check($sformatf("v%0d instr_done", i), 32'(instr_done), 32'(vecs[i].e_done));
      check($sformatf("v%0d fault", i),      32'(fault),      32'(vecs[i].e_fault));
      check($sformatf("v%0d fault_code", i), 32'(fault_code), 32'(vecs[i].e_code));
    end

    // Dispatch with ir_valid arriving late, bounded wait, then a single instr_done pulse.
    @(negedge clk);
    drive(1'b1, NXT, 3'd0, 12'h000, 4'h0, 1'b0, 8'h01, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b1, DSP, 3'd0, 12'h000, 4'h0, 1'b0, 8'h01, 1'b0, 1'b0);
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (upc == 12'h104) seen = 1;
      if (c == 2) ir_valid = 1'b1;
    end
    check("late dispatch reached 0x104", 32'(seen), 32'd1);
    drive(1'b1, FET, 3'd0, 12'h000, 4'h0, 1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b1, NXT, 3'd0, 12'h000, 4'h0, 1'b0, 8'h00, 1'b0, 1'b0);
    pulses = (instr_done === 1'b1) ? 1 : 0;
    check("upc after fetch", 32'(upc), 32'h000);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (instr_done === 1'b1) pulses++;
    end
    check("instr_done pulse count", 32'(pulses), 32'd1);
    check("upc after NEXT x4", 32'(upc), 32'h004);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
